// File: rtl/pipelined_divider_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_divider_pkg
//   Shared constants and helpers for the pipelined unsigned divider.
//   - DIV_DEFAULT_WIDTH : default operand width in bits
//   - div_latency()     : pipeline depth for a given operand width; one
//                         restoring-division stage per quotient bit
// -----------------------------------------------------------------------------
package pipelined_divider_pkg;

  localparam int DIV_DEFAULT_WIDTH = 4;

  // Each stage resolves exactly one quotient bit, so depth equals width.
  function automatic int div_latency(input int width);
    return width;
  endfunction

endpackage : pipelined_divider_pkg

// File: rtl/pipelined_divider_stage.sv
// -----------------------------------------------------------------------------
// pipelined_divider_stage
//   One registered restoring-division step. Stage STAGE resolves quotient bit
//   N-1-STAGE.
//
//   Parameters
//     N      operand width
//     STAGE  position in the pipeline, 0 = first
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     valid      incoming item valid
//     divisor    incoming divisor
//     rem        incoming partial remainder
//     dividend   incoming dividend (full word, this stage consumes one bit)
//     quo        incoming partial quotient (bits below this stage still 0)
//     dbz        incoming divide-by-zero flag
//     *_q        the same fields, registered, for the next stage
// -----------------------------------------------------------------------------
module pipelined_divider_stage #(
  parameter int N     = 4,
  parameter int STAGE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [N-1:0] divisor,
  input  logic [N-1:0] rem,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] quo,
  input  logic         dbz,
  output logic         valid_q,
  output logic [N-1:0] divisor_q,
  output logic [N-1:0] rem_q,
  output logic [N-1:0] dividend_q,
  output logic [N-1:0] quo_q,
  output logic         dbz_q
);

  localparam int BIT = N - 1 - STAGE;

  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         fits;
  logic [N-1:0] rem_next;
  logic [N-1:0] quo_next;

  // Shift-in and trial subtract at N+1 bits. The borrow out of the
  // subtraction (diff[N]) is set exactly when shifted < divisor, so it
  // doubles as the compare result. The partial remainder entering a stage
  // is always below the divisor, which keeps the restored or reduced value
  // within N bits. A zero divisor always "fits", which yields an all-ones
  // quotient and a remainder equal to the dividend without special casing.
  always_comb begin
    shifted  = {rem, dividend[BIT]};
    diff     = shifted - {1'b0, divisor};
    fits     = ~diff[N];
    rem_next = fits ? diff[N-1:0] : shifted[N-1:0];
    quo_next = quo;
    quo_next[BIT] = fits;
  end

  // Data only advances with a valid item; bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
      quo_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      valid_q <= valid;
      if (valid) begin
        divisor_q  <= divisor;
        rem_q      <= rem_next;
        dividend_q <= dividend;
        quo_q      <= quo_next;
        dbz_q      <= dbz;
      end
    end
  end

endmodule : pipelined_divider_stage

// File: rtl/pipelined_divider.sv
// -----------------------------------------------------------------------------
// pipelined_divider
//   Fully pipelined unsigned integer divider. One dividend/divisor pair may be
//   accepted per clock; quotient and remainder appear LATENCY (= N) clocks
//   later with a single-cycle out_valid strobe, in strict FIFO order.
//
//   Handshake: in_valid/out_valid form a push-only stream. There is no ready
//   in either direction; an item is accepted on every rising edge where
//   in_valid is 1 and rst is high, and its result is presented for exactly one
//   cycle with out_valid=1 N edges later. The consumer must take it then.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset; flushes all in-flight items
//     in_valid     operands valid this cycle
//     dividend     unsigned dividend, N bits
//     divisor      unsigned divisor, N bits
//     quotient     registered quotient, held between results
//     remainder    registered remainder, held between results
//     out_valid    one-cycle strobe per accepted input
//     div_by_zero  qualified by out_valid; divisor of that result was 0
// -----------------------------------------------------------------------------
module pipelined_divider
  import pipelined_divider_pkg::*;
#(
  parameter int N = DIV_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         out_valid,
  output logic         div_by_zero
);

  localparam int LATENCY = div_latency(N);

  // Per-stage registered fields; element i is the output of stage i.
  logic         st_valid    [LATENCY];
  logic [N-1:0] st_divisor  [LATENCY];
  logic [N-1:0] st_rem      [LATENCY];
  logic [N-1:0] st_dividend [LATENCY];
  logic [N-1:0] st_quo      [LATENCY];
  logic         st_dbz      [LATENCY];

  // Divide-by-zero is decided once at entry and simply carried along.
  logic in_dbz;
  assign in_dbz = (divisor == '0);

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_first
      pipelined_divider_stage #(
        .N     (N),
        .STAGE (i)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .valid      (in_valid),
        .divisor    (divisor),
        .rem        ('0),
        .dividend   (dividend),
        .quo        ('0),
        .dbz        (in_dbz),
        .valid_q    (st_valid[i]),
        .divisor_q  (st_divisor[i]),
        .rem_q      (st_rem[i]),
        .dividend_q (st_dividend[i]),
        .quo_q      (st_quo[i]),
        .dbz_q      (st_dbz[i])
      );
    end else begin : g_rest
      pipelined_divider_stage #(
        .N     (N),
        .STAGE (i)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .valid      (st_valid[i-1]),
        .divisor    (st_divisor[i-1]),
        .rem        (st_rem[i-1]),
        .dividend   (st_dividend[i-1]),
        .quo        (st_quo[i-1]),
        .dbz        (st_dbz[i-1]),
        .valid_q    (st_valid[i]),
        .divisor_q  (st_divisor[i]),
        .rem_q      (st_rem[i]),
        .dividend_q (st_dividend[i]),
        .quo_q      (st_quo[i]),
        .dbz_q      (st_dbz[i])
      );
    end
  end

  // Output hold registers: the result fields only change when the last stage
  // delivers an item, so downstream logic can keep reading the last result
  // across idle cycles. The final partial remainder is the true remainder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= st_valid[LATENCY-1];
      if (st_valid[LATENCY-1]) begin
        quotient    <= st_quo[LATENCY-1];
        remainder   <= st_rem[LATENCY-1];
        div_by_zero <= st_dbz[LATENCY-1];
      end
    end
  end

endmodule : pipelined_divider

// File: tb/tb_pipelined_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_divider
//   Directed and randomized stimulus for pipelined_divider (N=4). A monitor on
//   the falling edge compares every cycle's outputs against a reference built
//   from plain integer division and an expected-result queue.
// -----------------------------------------------------------------------------
module tb_pipelined_divider;

  localparam int N   = 4;
  localparam int LAT = N;
  localparam int W   = 2 * N + 1;  // {dbz, quotient, remainder}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor  = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         out_valid;
  logic         div_by_zero;

  always #5 clk = ~clk;

  pipelined_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .out_valid   (out_valid),
    .div_by_zero (div_by_zero)
  );

  // ---------------------------------------------------------------------------
  // Reference model: plain arithmetic, divide-by-zero per the defined result
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q;
    logic [N-1:0] r;
    if (b == '0) return {1'b1, {N{1'b1}}, a};
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] last_res = '0;
  int           edge_cnt = 0;
  int           checks   = 0;
  int           errors   = 0;
  int           results  = 0;

  // Inputs and rst only change 1ns after a falling edge, so at the falling
  // edge they still show what the preceding rising edge sampled.
  always @(negedge clk) begin
    logic         exp_valid;
    logic [W-1:0] exp_res;
    edge_cnt++;
    if (!rst) begin
      exp_q.delete();
      due_q.delete();
      last_res = '0;
      checks++;
      assert ({out_valid, div_by_zero, quotient, remainder} === '0)
      else begin
        errors++;
        $error("FAIL reset_outputs: got v=%0b dbz=%0b q=%0d r=%0d, want all 0",
               out_valid, div_by_zero, quotient, remainder);
      end
    end else begin
      exp_valid = (due_q.size() > 0) && (due_q[0] == edge_cnt);
      checks++;
      assert (out_valid === exp_valid)
      else begin
        errors++;
        $error("FAIL out_valid @edge %0d: got %0b, want %0b", edge_cnt, out_valid, exp_valid);
      end
      if (exp_valid) begin
        exp_res = exp_q.pop_front();
        void'(due_q.pop_front());
        last_res = exp_res;
        results++;
      end
      // Covers both a fresh result and the held value across gaps.
      checks++;
      assert ({div_by_zero, quotient, remainder} === last_res)
      else begin
        errors++;
        $error("FAIL result @edge %0d: got dbz=%0b q=%0d r=%0d, want dbz=%0b q=%0d r=%0d",
               edge_cnt, div_by_zero, quotient, remainder,
               last_res[W-1], last_res[2*N-1:N], last_res[N-1:0]);
      end
      if (in_valid) begin
        exp_q.push_back(ref_div(dividend, divisor));
        due_q.push_back(edge_cnt + LAT);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    #1;
    in_valid = v;
    dividend = a;
    divisor  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic put_reset(input logic level);
    @(negedge clk);
    #1;
    rst = level;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int got_before;
    #12 rst = 1'b1;

    // 1: single pulse 13/3 -> q=4 r=1
    drive(1'b1, 4'd13, 4'd3);
    idle(6);

    // 2: divide by zero and identities
    drive(1'b1, 4'd15, 4'd0);
    drive(1'b1, 4'd7,  4'd9);
    drive(1'b1, 4'd15, 4'd1);
    idle(6);

    // 3: back-to-back stream i/(10-i)
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 4'(10 - i));
    idle(6);

    // 4: gapped pattern 1,0,1,1,0
    drive(1'b1, 4'd11, 4'd2);
    drive(1'b0, 4'd5,  4'd5);
    drive(1'b1, 4'd6,  4'd4);
    drive(1'b1, 4'd14, 4'd3);
    drive(1'b0, 4'd9,  4'd9);
    idle(6);

    // 5: reset while two items are in flight; inputs during reset ignored
    got_before = results;
    drive(1'b1, 4'd12, 4'd5);
    drive(1'b1, 4'd8,  4'd3);
    idle(1);
    put_reset(1'b0);
    drive(1'b1, 4'd3, 4'd2);
    drive(1'b1, 4'd4, 4'd2);
    put_reset(1'b1);
    in_valid = 1'b0;
    idle(8);
    checks++;
    assert (results === got_before)
    else begin
      errors++;
      $error("FAIL flush_count: got %0d results after reset, want %0d", results, got_before);
    end

    // 6: exhaustive sweep at full rate
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(1'b1, 4'(a), 4'(b));
    idle(6);

    // Random traffic with random gaps
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(8);

    checks++;
    assert (exp_q.size() === 0)
    else begin
      errors++;
      $error("FAIL drain: %0d results still expected, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipelined_divider
